seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits; the product width SHALL be 2*WIDTH.
REQ-002 Port clock  input  1: single clock; all state SHALL update on the rising edge.
REQ-003 Port reset  input  1: asynchronous, active-high reset.
REQ-004 Port start  input  1: request a multiply; sampled on the rising edge.
REQ-005 Port is_signed  input  1: 1 = two's-complement operands (mult); 0 = unsigned (multu); sampled with start.
REQ-006 Port op_a  input  WIDTH: multiplicand, bit 0 = MSB; sampled with start.
REQ-007 Port op_b  input  WIDTH: multiplier, bit 0 = MSB; sampled with start.
REQ-008 Port busy  output  1: high while an operation is in progress.
REQ-009 Port done  output  1: one-cycle pulse marking the product as valid.
REQ-010 Port product_hi  output  WIDTH: upper half of the product, bit 0 = MSB.
REQ-011 Port product_lo  output  WIDTH: lower half of the product; the datapath feeds this to the aluOrMultOut select.

Function
REQ-012 The block SHALL implement states IDLE, BUSY and DONE, held in registers.
REQ-013 IDLE: start=1 SHALL latch op_a, op_b and is_signed, clear the accumulator and the iteration counter, and move to BUSY; start=0 SHALL stay in IDLE.
REQ-014 Operand changes after the start edge SHALL NOT affect the result.
REQ-015 Signed mode: the block SHALL latch operand magnitudes and the sign = MSB(op_a) XOR MSB(op_b); unsigned mode SHALL use the sign 0.
REQ-016 BUSY: each edge SHALL perform one radix-2 shift-add step on a 2*WIDTH accumulator and increment the counter.
REQ-017 BUSY SHALL last exactly WIDTH edges; the WIDTH-th edge SHALL write the final product and move to DONE.
REQ-018 Latency: done=1 and the product SHALL be valid in the cycle following the WIDTH-th edge after the start edge (32 edges at the default width); there SHALL be no early-out for zero operands.
REQ-019 Final product: when the latched sign is 1, it SHALL be the two's-complement negation of the unsigned magnitude product, computed on the full 2*WIDTH bits.
REQ-020 DONE SHALL last one cycle: the next edge SHALL go to BUSY if start=1 (back-to-back, with new operands latched), otherwise to IDLE.
REQ-021 busy SHALL equal 1 exactly in BUSY; done SHALL equal 1 exactly in DONE; both SHALL be registered.
REQ-022 start while BUSY SHALL be ignored, with no effect on the operation in progress.
REQ-023 product_hi and product_lo SHALL hold the last completed product until the final edge of the next operation, and SHALL NOT show partial sums.
REQ-024 Boundary: signed (-2^(WIDTH-1)) x (-2^(WIDTH-1)) SHALL yield +2^(2*WIDTH-2) with no overflow; the counter SHALL NOT wrap past WIDTH.

Reset
REQ-025 Assertion of reset SHALL, without waiting for a clock edge, force IDLE, busy=0, done=0, product_hi=0, product_lo=0, and clear the counter and accumulator.
REQ-026 Reset asserted mid-BUSY SHALL abort the operation, and no done pulse SHALL follow.
REQ-027 After deassertion, the first rising edge with start=1 SHALL begin a new operation normally.

Verification
REQ-028 Unsigned: op_a=0x00000007, op_b=0x00000006, is_signed=0, start for 1 cycle -> busy for 32 cycles, then done for 1 cycle with hi=0x00000000, lo=0x0000002A.
REQ-029 Signed: op_a=0xFFFFFFFD (-3), op_b=0x00000005, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; same operands with is_signed=0 -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-030 Extremes: 0x80000000 x 0x80000000 signed -> hi=0x40000000, lo=0x00000000; 0xFFFFFFFF x 0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 Ignored start and operand hold: start pulsed at busy cycle 10 with other operands, and operands changed during BUSY -> result matches the originally latched operands; done pulses exactly once.
REQ-032 Back-to-back: start held high through DONE -> the second operation starts at the DONE edge; busy rises the cycle after done, and the second done comes 32 edges later.
REQ-033 Reset mid-op: reset asserted at busy cycle 15 -> busy=0 and outputs=0 immediately with no clock edge; no done pulse; a subsequent 2x3 unsigned multiply returns lo=0x00000006.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, signed/unsigned, one product
// bit per clock, WIDTH busy cycles followed by a one-cycle done pulse.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [0:WIDTH-1]   op_a,
    input  logic [0:WIDTH-1]   op_b,
    output logic               busy,
    output logic               done,
    output logic [0:WIDTH-1]   product_hi,
    output logic [WIDTH-1:0]   product_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     a_u, b_u, mag_a, mag_b, mplier;
    logic [2*WIDTH-1:0]   mcand, acc, acc_n;
    logic [CW-1:0]        cnt;
    logic                 neg, load, last;

    // Operands are numerically MSB-first on the ports; work on plain descending copies.
    assign a_u   = op_a;
    assign b_u   = op_b;
    assign mag_a = (is_signed && a_u[WIDTH-1]) ? -a_u : a_u;
    assign mag_b = (is_signed && b_u[WIDTH-1]) ? -b_u : b_u;
    assign load  = start && state != BUSY;
    assign last  = cnt == CW'(WIDTH - 1);
    assign acc_n = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                                  (start ? BUSY : IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            state <= state_n;
            busy  <= state_n == BUSY;
            done  <= state_n == DONE;
            if (load) begin
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= '0;
                neg    <= is_signed && (a_u[WIDTH-1] ^ b_u[WIDTH-1]);
            end else if (state == BUSY) begin
                acc    <= acc_n;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // Outputs only change on the final step, so partial sums never show.
                if (last) {product_hi, product_lo} <= neg ? -acc_n : acc_n;
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed tests with a cycle-level reference model and
// hand-computed expectations.
module tb_seq_multiplier;
    localparam int WIDTH = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              is_signed = 1'b0;
    logic [WIDTH-1:0]  op_a = '0, op_b = '0;
    logic              busy, done;
    logic [WIDTH-1:0]  product_hi, product_lo;

    int tests = 0, fails = 0;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .product_hi(product_hi), .product_lo(product_lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model_prod(logic [31:0] a, logic [31:0] b, logic s);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return s ? 64'(sa * sb) : 64'(a) * 64'(b);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted start makes the block busy for WIDTH cycles, then done for one.
    bit          m_busy, m_done;
    int          m_rem;
    logic [63:0] m_prod, m_pend;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_rem = 0; m_prod = '0; m_pend = '0;
        end else begin
            bit acc_ok;
            acc_ok = start && !m_busy;
            m_done = 0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0; m_done = 1; m_prod = m_pend;
                end
            end
            if (acc_ok) begin
                m_busy = 1; m_rem = WIDTH; m_pend = model_prod(op_a, op_b, is_signed);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("model_busy", 64'(busy), 64'(m_busy));
            chk("model_done", 64'(done), 64'(m_done));
            chk("model_product", {product_hi, product_lo}, m_prod);
        end
    end

    task automatic issue(logic [31:0] a, logic [31:0] b, logic s);
        @(negedge clock);
        op_a = a; op_b = b; is_signed = s; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at the negedge following the start edge; returns at the done cycle.
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin seen = 1; break; end
            nbusy += int'(busy);
            @(negedge clock);
        end
    endtask

    task automatic run_op(string name, logic [31:0] a, logic [31:0] b, logic s,
                          logic [31:0] ehi, logic [31:0] elo);
        int nb; bit seen;
        issue(a, b, s);
        wait_done(nb, seen);
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_busy_cycles"}, 64'(nb), 64'd32);
        chk({name, "_hi"}, 64'(product_hi), 64'(ehi));
        chk({name, "_lo"}, 64'(product_lo), 64'(elo));
    endtask

    initial begin
        int nb, ndone; bit seen;
        chk("pin_signed", model_prod(32'hFFFFFFFD, 32'h5, 1'b1), 64'hFFFFFFFF_FFFFFFF1);
        chk("pin_unsigned", model_prod(32'hFFFFFFFD, 32'h5, 1'b0), 64'h00000004_FFFFFFF1);
        chk("pin_min_sq", model_prod(32'h80000000, 32'h80000000, 1'b1), 64'h40000000_00000000);
        repeat (2) @(negedge clock);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", {product_hi, product_lo}, 64'd0);
        #2 reset = 1'b0;

        run_op("u7x6", 32'h7, 32'h6, 1'b0, 32'h0, 32'h2A);
        run_op("s_m3x5", 32'hFFFFFFFD, 32'h5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("u_m3x5", 32'hFFFFFFFD, 32'h5, 1'b0, 32'h4, 32'hFFFFFFF1);
        run_op("s_min_sq", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0);
        run_op("u_max_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1);
        run_op("zero", 32'h0, 32'h12345678, 1'b1, 32'h0, 32'h0);
        run_op("s_neg_neg", 32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 32'h0, 32'h2A);

        // Start during BUSY is ignored and operand changes after the start edge have no effect.
        issue(32'd12345, 32'd678, 1'b0);
        repeat (9) @(negedge clock);
        op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D; is_signed = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0; op_a = 32'h1; op_b = 32'h2;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            ndone += int'(done);
            if (done) begin
                chk("ignore_hi", 64'(product_hi), 64'h0);
                chk("ignore_lo", 64'(product_lo), 64'h7FB6F6);
            end
            @(negedge clock);
        end
        chk("ignore_done_count", 64'(ndone), 64'd1);

        // Back-to-back: start held through DONE launches the next operation at that edge.
        @(negedge clock);
        op_a = 32'd3; op_b = 32'd4; is_signed = 1'b0; start = 1'b1;
        @(negedge clock);
        op_a = 32'd5; op_b = 32'd5;
        wait_done(nb, seen);
        chk("b2b_first_done", 64'(seen), 64'd1);
        chk("b2b_first_lo", 64'(product_lo), 64'hC);
        @(negedge clock);
        start = 1'b0;
        chk("b2b_busy_after_done", 64'(busy), 64'd1);
        chk("b2b_lo_held", 64'(product_lo), 64'hC);
        @(negedge clock);
        wait_done(nb, seen);
        chk("b2b_second_done", 64'(seen), 64'd1);
        chk("b2b_second_busy", 64'(nb + 1), 64'd32);
        chk("b2b_second_lo", 64'(product_lo), 64'h19);

        // Asynchronous reset in the middle of an operation.
        issue(32'd1000, 32'd1000, 1'b0);
        repeat (14) @(negedge clock);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_prod", {product_hi, product_lo}, 64'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            ndone += int'(done);
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op("post_reset_2x3", 32'd2, 32'd3, 1'b0, 32'h0, 32'h6);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
